mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory controller between the core and the byte-wide RAM/IO port.
- Arbitrates between instruction-fetch word reads and load/store requests issued by the load/store buffer.
- Serialises each access into 1–4 byte cycles.
- Returns fetch words to the fetcher, returns load results on the load CDB, and signals completion back to the load/store buffer.

Parameters:
IO_HI, 2'b11, addr[17:16] value identifying the IO region (writes to it obey io_buffer_full)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; low freezes all state
rollback  in  1  misprediction flush; aborts in-flight fetch
mem_din  in  8  RAM read byte (valid one cycle after address)
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1=write, 0=read
io_buffer_full  in  1  IO write back-pressure
if_req_flag  in  1  fetch request (level)
if_req_addr  in  32  fetch address
if_done_flag  out  1  fetch word valid (1-cycle pulse)
if_done_data  out  32  fetched word, little-endian
lsb_req_flag  in  1  LSB request (registered level, may stay high stale)
lsb_req_width  in  2  00 byte, 01 half, 10 word
lsb_req_type  in  1  0 load, 1 store
lsb_req_sext  in  1  1 = sign-extend load result
lsb_req_addr  in  32  byte address
lsb_req_data  in  32  store data
lsb_req_rob_id  in  ROBBW  ROB tag of request
lsb_done_flag  out  1  LSB access complete (1-cycle pulse)
ld_cdb_flag  out  1  load result broadcast (1-cycle pulse)
ld_cdb_rob_id  out  ROBBW  tag of broadcast
ld_cdb_val  out  32  extended load value

Behaviour:
- Reset (async, any time): state IDLE, byte counter 0, all outputs 0 (mem_wr=0, mem_a=0, mem_dout=0, all flags 0, data/val/tag 0). Any partial access is discarded.
- rdy low: hold all state and outputs, except mem_wr forced 0.
- Flag outputs are single-cycle pulses, cleared on the next rdy cycle.
- States:
  - IDLE
  - LS_READ
  - LS_WRITE
  - IF_READ
  - COOLDOWN
- IDLE arbitration, evaluated each cycle:
  - lsb_req_flag has priority over if_req_flag.
  - All request fields (addr, width, type, sext, data, rob_id) are latched at acceptance.
  - n = 1/2/4 bytes from width; fetch is always 4 bytes.
- Reads (LS_READ, IF_READ):
  - Accept in cycle 0.
  - mem_a = addr+k, mem_wr=0 in cycle k+1, for k = 0..n-1.
  - Byte k captured from mem_din in cycle k+2 into bits [8k+7:8k].
  - Completion pulse in cycle n+2; then return to IDLE (fetch) or COOLDOWN (LSB).
  - Byte load takes 3 cycles accept-to-done; word load/fetch takes 6.
- Load completion:
  - lsb_done_flag=1, ld_cdb_flag=1, ld_cdb_rob_id = latched tag, same cycle.
  - ld_cdb_val is zero-extended, or sign-extended from bit 8n-1 when sext=1.
- Writes (LS_WRITE):
  - Cycle k+1: mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k].
  - Completion pulse in cycle n+1 (lsb_done_flag only; ld_cdb_flag stays 0). Then COOLDOWN.
  - Word store takes 5 cycles accept-to-done.
- IO write stall: if addr[17:16]==IO_HI and io_buffer_full=1 in a byte cycle, drive mem_wr=0, do not advance k, and retry next cycle.
- COOLDOWN:
  - Exactly one cycle; lsb_req_flag is ignored there and in the done-pulse cycle (stale request level).
  - Fetch may be accepted from COOLDOWN.
- 32-bit address increment wraps modulo 2^32.
- rollback=1 during IF_READ:
  - Abort immediately and return to IDLE next cycle; no if_done pulse for that fetch.
  - A new fetch may be accepted the cycle after.
- rollback has no effect on LS_READ/LS_WRITE; these always complete.
- rollback in IDLE blocks fetch acceptance that cycle.
- No new request is accepted while any access is in flight.

Test Plan:
- Word fetch 0x1000, RAM bytes 13,00,00,93 -> if_done_flag one pulse 6 cycles after accept, if_done_data=0x93000013, mem_a sequence 1000..1003.
- LB with sext=1 at a byte 0x80, rob_id=3 -> ld_cdb_val=0xFFFFFF80, ld_cdb_rob_id=3, lsb_done_flag and ld_cdb_flag same cycle, 3 cycles after accept; with sext=0 -> 0x00000080.
- SW 0xDEADBEEF to 0x2000 -> mem_wr=1 four cycles, mem_dout EF,BE,AD,DE at 2000..2003; lsb_done_flag pulse 5 cycles after accept; ld_cdb_flag stays 0.
- lsb_req_flag and if_req_flag both high in IDLE -> LSB served first; stale lsb_req_flag held high through done not re-accepted; fetch accepted in COOLDOWN.
- SB to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low those 3 cycles, then one write of the byte; done delayed by exactly 3 cycles.
- rollback in 2nd byte cycle of a fetch -> no if_done_flag, IDLE next cycle; async rst mid word-store -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB loads/stores against instruction
// fetches and splits each access into 1-4 byte cycles on the RAM/IO port.
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11,
    parameter int          ROBBW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    input  logic             io_buffer_full,
    input  logic             if_req_flag,
    input  logic [31:0]      if_req_addr,
    output logic             if_done_flag,
    output logic [31:0]      if_done_data,
    input  logic             lsb_req_flag,
    input  logic [1:0]       lsb_req_width,
    input  logic             lsb_req_type,
    input  logic             lsb_req_sext,
    input  logic [31:0]      lsb_req_addr,
    input  logic [31:0]      lsb_req_data,
    input  logic [ROBBW-1:0] lsb_req_rob_id,
    output logic             lsb_done_flag,
    output logic             ld_cdb_flag,
    output logic [ROBBW-1:0] ld_cdb_rob_id,
    output logic [31:0]      ld_cdb_val
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LS_READ  = 3'd1,
        LS_WRITE = 3'd2,
        IF_READ  = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] w,
                                                input logic sext);
        case (w)
            2'b00:   return sext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            2'b01:   return sext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       width_q, width_d;
    logic             sext_q, sext_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [ROBBW-1:0] rob_q, rob_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      mem_a_q, mem_a_d;
    logic [7:0]       mem_dout_q, mem_dout_d;
    logic             wr_q, wr_d;
    logic             if_done_q, if_done_d;
    logic [31:0]      if_data_q, if_data_d;
    logic             lsb_done_q, lsb_done_d;
    logic             cdb_flag_q, cdb_flag_d;
    logic [ROBBW-1:0] cdb_rob_q, cdb_rob_d;
    logic [31:0]      cdb_val_q, cdb_val_d;

    logic [2:0]       n_s;
    logic             stall_s;
    logic             fetch_go_s;
    logic [1:0]       rd_idx_s;
    logic [1:0]       wr_idx_s;
    logic [31:0]      next_off_s;

    assign n_s     = width_bytes(width_q);
    assign stall_s = (state_q == LS_WRITE) && (addr_q[17:16] == IO_HI) && io_buffer_full;

    // Next-state, byte sequencing and completion pulses
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        width_d    = width_q;
        sext_d     = sext_q;
        wdata_d    = wdata_q;
        rob_d      = rob_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        wr_d       = wr_q;
        if_done_d  = if_done_q;
        if_data_d  = if_data_q;
        lsb_done_d = lsb_done_q;
        cdb_flag_d = cdb_flag_q;
        cdb_rob_d  = cdb_rob_q;
        cdb_val_d  = cdb_val_q;
        fetch_go_s = 1'b0;
        // mem_din lags the address by one cycle, so the byte arriving now is cnt-1
        rd_idx_s   = cnt_q[1:0] - 2'd1;
        wr_idx_s   = cnt_q[1:0] + 2'd1;
        next_off_s = {29'd0, cnt_q + 3'd1};

        if (rdy) begin
            if_done_d  = 1'b0;
            lsb_done_d = 1'b0;
            cdb_flag_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsb_req_flag) begin
                        addr_d     = lsb_req_addr;
                        width_d    = lsb_req_width;
                        sext_d     = lsb_req_sext;
                        wdata_d    = lsb_req_data;
                        rob_d      = lsb_req_rob_id;
                        cnt_d      = 3'd0;
                        buf_d      = 32'd0;
                        mem_a_d    = lsb_req_addr;
                        if (lsb_req_type) begin
                            state_d    = LS_WRITE;
                            wr_d       = 1'b1;
                            mem_dout_d = lsb_req_data[7:0];
                        end else begin
                            state_d    = LS_READ;
                            wr_d       = 1'b0;
                        end
                    end else if (if_req_flag && !rollback) begin
                        fetch_go_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                COOLDOWN: begin
                    state_d    = IDLE;
                    fetch_go_s = if_req_flag && !rollback;
                end
                LS_READ, IF_READ: begin
                    if ((state_q == IF_READ) && rollback) begin
                        state_d = IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            buf_d[{rd_idx_s, 3'b000} +: 8] = mem_din;
                        end else begin
                            buf_d = buf_q;
                        end
                        if (cnt_q == n_s) begin
                            if (state_q == IF_READ) begin
                                if_done_d = 1'b1;
                                if_data_d = buf_d;
                                state_d   = IDLE;
                            end else begin
                                lsb_done_d = 1'b1;
                                cdb_flag_d = 1'b1;
                                cdb_rob_d  = rob_q;
                                cdb_val_d  = extend_load(buf_d, width_q, sext_q);
                                state_d    = COOLDOWN;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if ((cnt_q + 3'd1) < n_s) begin
                                mem_a_d = addr_q + next_off_s;
                            end else begin
                                mem_a_d = mem_a_q;
                            end
                        end
                    end
                end
                LS_WRITE: begin
                    if (stall_s) begin
                        cnt_d = cnt_q;
                    end else if ((cnt_q + 3'd1) == n_s) begin
                        lsb_done_d = 1'b1;
                        wr_d       = 1'b0;
                        state_d    = COOLDOWN;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = addr_q + next_off_s;
                        mem_dout_d = wdata_q[{wr_idx_s, 3'b000} +: 8];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (fetch_go_s) begin
                state_d = IF_READ;
                addr_d  = if_req_addr;
                width_d = 2'b10;
                sext_d  = 1'b0;
                cnt_d   = 3'd0;
                buf_d   = 32'd0;
                mem_a_d = if_req_addr;
                wr_d    = 1'b0;
            end else begin
                fetch_go_s = 1'b0;
            end
        end else begin
            fetch_go_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 32'd0;
            width_q    <= 2'b00;
            sext_q     <= 1'b0;
            wdata_q    <= 32'd0;
            rob_q      <= '0;
            buf_q      <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            lsb_done_q <= 1'b0;
            cdb_flag_q <= 1'b0;
            cdb_rob_q  <= '0;
            cdb_val_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            sext_q     <= sext_d;
            wdata_q    <= wdata_d;
            rob_q      <= rob_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            lsb_done_q <= lsb_done_d;
            cdb_flag_q <= cdb_flag_d;
            cdb_rob_q  <= cdb_rob_d;
            cdb_val_q  <= cdb_val_d;
        end
    end

    // The write strobe must drop in the same cycle as a freeze or IO back-pressure
    assign mem_wr        = wr_q && rdy && !stall_s;
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign if_done_flag  = if_done_q;
    assign if_done_data  = if_data_q;
    assign lsb_done_flag = lsb_done_q;
    assign ld_cdb_flag   = cdb_flag_q;
    assign ld_cdb_rob_id = cdb_rob_q;
    assign ld_cdb_val    = cdb_val_q;

endmodule
